// File: rtl/key_uart_tx.sv
// Keypad-to-UART transmit: encodes key presses to ASCII, queues them in a small FIFO and
// hands bytes to the UART over txdata/txclk/txready. Optional KEY_TX_CRLF_EN sends code 16 as CR LF.
module key_uart_tx #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     keyclk,
  input  logic [4:0]               keycode,
  input  logic                     txready,
  output logic [7:0]               txdata,
  output logic                     txclk,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = AddrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StPulse, StWait} state_e;

  state_e               state_q, state_d;
  logic                 kd_q;
  logic [7:0]           mem [DEPTH];
  logic [AddrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q, count_d;
  logic [7:0]           txdata_q;
  logic                 txclk_q, txclk_d;
  logic                 overflow_q, overflow_d;
  logic                 press, push, pop;
  logic [7:0]           push_byte;

  function automatic logic [7:0] encode(input logic [4:0] code);
    logic [7:0] c;
    c = {3'b000, code};
    if (code < 5'd10)      return 8'h30 + c;
    else if (code < 5'd16) return 8'h37 + c;
    else if (code < 5'd20) return 8'h47 + c;
    else                   return 8'h3F;
  endfunction

  assign press = keyclk & ~kd_q;

`ifdef KEY_TX_CRLF_EN
  logic       lf_pend_q, lf_pend_d;
  logic       defer_q, defer_d;
  logic [4:0] defer_code_q, defer_code_d;
  logic [4:0] src_code;

  always_comb begin
    push         = 1'b0;
    push_byte    = 8'h00;
    overflow_d   = overflow_q;
    lf_pend_d    = 1'b0;
    defer_d      = 1'b0;
    defer_code_d = defer_code_q;
    src_code     = defer_q ? defer_code_q : keycode;
    if (lf_pend_q) begin
      // Room for the LF was reserved when the CR was accepted.
      push      = 1'b1;
      push_byte = 8'h0A;
      if (press) begin
        defer_d      = 1'b1;
        defer_code_d = keycode;
      end
    end else if (press || defer_q) begin
      if (src_code == 5'd16) begin
        if (count_q <= CntW'(DEPTH - 2)) begin
          push      = 1'b1;
          push_byte = 8'h0D;
          lf_pend_d = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end else if (count_q == FullCnt) begin
        overflow_d = 1'b1;
      end else begin
        push      = 1'b1;
        push_byte = encode(src_code);
      end
    end
  end
`else
  always_comb begin
    push       = 1'b0;
    push_byte  = encode(keycode);
    overflow_d = overflow_q;
    if (press) begin
      if (count_q == FullCnt) overflow_d = 1'b1;
      else                    push = 1'b1;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    txclk_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0 && txready) begin
          pop     = 1'b1;
          txclk_d = 1'b1;
          state_d = StPulse;
        end
      end
      StPulse: state_d = StWait;
      StWait:  if (!txready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CntW'(1);
    else if (pop && !push) count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_byte;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      kd_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      txdata_q   <= 8'h00;
      txclk_q    <= 1'b0;
      overflow_q <= 1'b0;
`ifdef KEY_TX_CRLF_EN
      lf_pend_q    <= 1'b0;
      defer_q      <= 1'b0;
      defer_code_q <= 5'd0;
`endif
    end else begin
      state_q    <= state_d;
      kd_q       <= keyclk;
      count_q    <= count_d;
      txclk_q    <= txclk_d;
      overflow_q <= overflow_d;
      if (push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AddrW'(1);
        txdata_q <= mem[rd_ptr_q];
      end
`ifdef KEY_TX_CRLF_EN
      lf_pend_q    <= lf_pend_d;
      defer_q      <= defer_d;
      defer_code_q <= defer_code_d;
`endif
    end
  end

  assign txdata   = txdata_q;
  assign txclk    = txclk_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule
